divider_radix4_seq: RTL and testbench

- Sequential restoring radix-4 divider, the inverse of the DSP-partitioned 80-bit multiplier in the phase_a datapath.
- Divides a 2*div_size-bit dividend by a div_size-bit divisor.
- Retires 2 quotient bits per cycle, matching the 2-bit upper-slice granularity used by the multiplier.
- Returns quotient and remainder with a single-cycle done pulse. Used to recover quotients and reductions from full-width products.

---
 rtl/divider_radix4_seq_pkg.sv | 20 ++
 rtl/divider_radix4_seq_digit_sel.sv | 38 +++
 rtl/divider_radix4_seq.sv | 128 ++++++++++++
 tb/tb_divider_radix4_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_radix4_seq_pkg.sv
// Shared constants and state encoding for the radix-4 sequential divider.
package divider_radix4_seq_pkg;

   localparam int DIV_SIZE = 80;
   localparam int ITERS    = DIV_SIZE / 2;
   localparam int LATENCY  = DIV_SIZE / 2 + 2;

   // state    | meaning
   // ST_IDLE  | waiting for en, outputs hold last result
   // ST_PRE   | build 3*b, load partial remainder, detect dz/ovf
   // ST_ITER  | retire one radix-4 quotient digit per cycle
   // ST_DONE  | one-cycle done pulse, results valid
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_ITER = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/divider_radix4_seq_digit_sel.sv
// Radix-4 restoring digit selection: picks the largest d in {3,2,1,0}
// with d*b <= t and returns the reduced remainder.
module div_radix4_digit_sel
   import divider_radix4_seq_pkg::*;
#(
   parameter int W = DIV_SIZE
) (
   input  logic [W+1:0] t,
   input  logic [W-1:0] b,
   input  logic [W+1:0] b3,
   output logic [1:0]   digit,
   output logic [W-1:0] rem_next
);

   logic [W+1:0] b1_x;
   logic [W+1:0] b2_x;

   assign b1_x = {2'b00, b};
   assign b2_x = {1'b0, b, 1'b0};

   // Full-width compares pick the digit; the remainder only needs the low
   // W bits because the true difference is always below b.
   always_comb begin
      digit    = 2'd0;
      rem_next = t[W-1:0];
      if (t >= b3) begin
         digit    = 2'd3;
         rem_next = t[W-1:0] - b3[W-1:0];
      end else if (t >= b2_x) begin
         digit    = 2'd2;
         rem_next = t[W-1:0] - b2_x[W-1:0];
      end else if (t >= b1_x) begin
         digit    = 2'd1;
         rem_next = t[W-1:0] - b;
      end
   end

endmodule

// File: rtl/divider_radix4_seq.sv
// Sequential restoring radix-4 divider: 2n-bit dividend by n-bit divisor,
// two quotient bits per cycle, single-cycle done pulse.
module divider_radix4_seq
   import divider_radix4_seq_pkg::*;
#(
   parameter int div_size = DIV_SIZE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [2*div_size-1:0]   a,
   input  logic [div_size-1:0]     b,
   output logic [div_size-1:0]     q,
   output logic [div_size-1:0]     r,
   output logic                    busy,
   output logic                    done,
   output logic                    dz,
   output logic                    ovf
);

   localparam int iters = div_size / 2;
   localparam int cnt_w = $clog2(iters);
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(iters - 1);

   state_t                  state;
   state_t                  state_next;
   logic [2*div_size-1:0]   a_lat;
   logic [div_size-1:0]     b_lat;
   logic [div_size+1:0]     b3;
   logic [div_size-1:0]     rem;
   logic [div_size-1:0]     sh;
   logic [cnt_w-1:0]        cnt;
   logic [div_size-1:0]     a_hi;
   logic [div_size+1:0]     t;
   logic [1:0]              digit;
   logic [div_size-1:0]     rem_next;
   logic                    err_dz;
   logic                    err_ovf;

   assign a_hi    = a_lat[2*div_size-1:div_size];
   assign err_dz  = (b_lat == '0);
   assign err_ovf = (a_hi >= b_lat);
   assign t       = {rem, sh[div_size-1:div_size-2]};

   div_radix4_digit_sel #(.W(div_size)) u_digit_sel (
      .t        (t),
      .b        (b_lat),
      .b3       (b3),
      .digit    (digit),
      .rem_next (rem_next)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (en) state_next = ST_PRE;
         ST_PRE:  state_next = (err_dz || err_ovf) ? ST_DONE : ST_ITER;
         ST_ITER: if (cnt == last_cnt) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      busy = (state == ST_PRE) || (state == ST_ITER);
      done = (state == ST_DONE);
   end

   // Datapath: operand capture, iteration registers and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_lat <= '0;
         b_lat <= '0;
         b3    <= '0;
         rem   <= '0;
         sh    <= '0;
         cnt   <= '0;
         q     <= '0;
         r     <= '0;
         dz    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (en) begin
                  a_lat <= a;
                  b_lat <= b;
                  dz    <= 1'b0;
                  ovf   <= 1'b0;
               end
            end
            ST_PRE: begin
               b3  <= {2'b00, b_lat} + {1'b0, b_lat, 1'b0};
               rem <= a_hi;
               sh  <= a_lat[div_size-1:0];
               cnt <= '0;
               q   <= '0;
               if (err_dz) begin
                  dz <= 1'b1;
                  q  <= '1;
                  r  <= '0;
               end else if (err_ovf) begin
                  ovf <= 1'b1;
                  q   <= '1;
                  r   <= '0;
               end
            end
            ST_ITER: begin
               rem <= rem_next;
               sh  <= {sh[div_size-3:0], 2'b00};
               q   <= {q[div_size-3:0], digit};
               cnt <= cnt + cnt_w'(1);
               if (cnt == last_cnt) r <= rem_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_radix4_seq.sv
// Self-checking bench for divider_radix4_seq (80-bit configuration).
module tb_divider_radix4_seq;

   logic          clk;
   logic          rst;
   logic          en;
   logic [159:0]  a;
   logic [79:0]   b;
   logic [79:0]   q;
   logic [79:0]   r;
   logic          busy;
   logic          done;
   logic          dz;
   logic          ovf;

   int n_checks;
   int n_fail;

   divider_radix4_seq dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .a    (a),
      .b    (b),
      .q    (q),
      .r    (r),
      .busy (busy),
      .done (done),
      .dz   (dz),
      .ovf  (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [79:0] rand80();
      logic [95:0] x;
      x = {$urandom(), $urandom(), $urandom()};
      return x[79:0];
   endfunction

   // Reference: plain wide-integer division plus the error rules.
   task automatic model(input logic [159:0] av, input logic [79:0] bv,
                        output logic [79:0] eq, output logic [79:0] er,
                        output logic edz, output logic eovf, output int elat);
      logic [159:0] qq;
      logic [159:0] rr;
      logic [79:0]  hi;
      hi = av[159:80];
      if (bv == 80'd0) begin
         edz = 1'b1; eovf = 1'b0; eq = '1; er = '0; elat = 2;
      end else if (hi >= bv) begin
         edz = 1'b0; eovf = 1'b1; eq = '1; er = '0; elat = 2;
      end else begin
         qq = av / {80'd0, bv};
         rr = av % {80'd0, bv};
         edz = 1'b0; eovf = 1'b0; eq = qq[79:0]; er = rr[79:0]; elat = 42;
      end
   endtask

   // Runs one operation from an IDLE cycle; returns what the DUT showed.
   // Ends positioned in the IDLE cycle right after done (plus post cycles).
   task automatic do_op(input logic [159:0] av, input logic [79:0] bv,
                        input int ign1, input int ign2, input int post,
                        output logic [79:0] oq, output logic [79:0] orr,
                        output logic odz, output logic oovf,
                        output int lat, output int busy_bad,
                        output int extra_done, output int hold_bad);
      int cyc;
      oq = 'x; orr = 'x; odz = 1'bx; oovf = 1'bx;
      lat = 0; busy_bad = 0; extra_done = 0; hold_bad = 0;
      en = 1'b1; a = av; b = bv;
      @(posedge clk); #1;
      en = 1'b0; a = {rand80(), rand80()}; b = rand80();
      cyc = 1;
      while (cyc <= 100 && lat == 0) begin
         if (done) begin
            lat = cyc; oq = q; orr = r; odz = dz; oovf = ovf;
            if (busy) busy_bad++;
         end else begin
            if (!busy) busy_bad++;
            if (cyc == ign1 || cyc == ign2) begin
               en = 1'b1; a = {rand80(), rand80()}; b = rand80();
            end
         end
         @(posedge clk); #1;
         en = 1'b0;
         cyc++;
      end
      for (int i = 0; i < post; i++) begin
         if (done) extra_done++;
         if (q !== oq || r !== orr || dz !== odz || ovf !== oovf) hold_bad++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({q, r} !== 160'd0) begin
         n_fail++; $display("FAIL reset_qr: got q=%h r=%h expected 0", q, r);
      end
      n_checks++;
      if ({busy, done, dz, ovf} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got busy/done/dz/ovf=%b expected 0000",
                            {busy, done, dz, ovf});
      end
      // en together with rst must be dropped
      en = 1'b1; a = 160'd100; b = 80'd7;
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_en_dropped: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_directed();
      logic [159:0] ta [3];
      logic [79:0]  tb [3];
      logic [79:0]  oq, orr, eq, er;
      logic         odz, oovf, edz, eovf;
      int           lat, elat, bb, xd, hb;
      ta[0] = 160'd100;         tb[0] = 80'd7;
      ta[1] = 160'd1 << 80;     tb[1] = 80'd2;
      ta[2] = ~160'd0 - (160'd1 << 80); tb[2] = ~80'd0;
      for (int i = 0; i < 3; i++) begin
         model(ta[i], tb[i], eq, er, edz, eovf, elat);
         do_op(ta[i], tb[i], -1, -1, 4, oq, orr, odz, oovf, lat, bb, xd, hb);
         n_checks++;
         if (oq !== eq || orr !== er) begin
            n_fail++; $display("FAIL directed%0d_qr: got q=%h r=%h expected q=%h r=%h",
                               i, oq, orr, eq, er);
         end
         n_checks++;
         if ({odz, oovf} !== {edz, eovf}) begin
            n_fail++; $display("FAIL directed%0d_flags: got dz/ovf=%b%b expected %b%b",
                               i, odz, oovf, edz, eovf);
         end
         n_checks++;
         if (lat !== elat) begin
            n_fail++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, elat);
         end
         n_checks++;
         if (bb !== 0 || xd !== 0 || hb !== 0) begin
            n_fail++; $display("FAIL directed%0d_busy_hold: busy errs=%0d extra done=%0d hold errs=%0d expected 0",
                               i, bb, xd, hb);
         end
      end
   endtask

   task automatic test_errors();
      logic [159:0] ta [2];
      logic [79:0]  tb [2];
      logic [79:0]  oq, orr;
      logic         odz, oovf;
      logic [1:0]   eflags [2];
      int           lat, bb, xd, hb;
      ta[0] = {rand80(), rand80()}; tb[0] = 80'd0;  eflags[0] = 2'b10;
      ta[1] = {80'd5, rand80()};    tb[1] = 80'd5;  eflags[1] = 2'b01;
      for (int i = 0; i < 2; i++) begin
         do_op(ta[i], tb[i], -1, -1, 3, oq, orr, odz, oovf, lat, bb, xd, hb);
         n_checks++;
         if ({odz, oovf} !== eflags[i]) begin
            n_fail++; $display("FAIL error%0d_flags: got dz/ovf=%b%b expected %b",
                               i, odz, oovf, eflags[i]);
         end
         n_checks++;
         if (oq !== ~80'd0 || orr !== 80'd0) begin
            n_fail++; $display("FAIL error%0d_qr: got q=%h r=%h expected all ones / 0", i, oq, orr);
         end
         n_checks++;
         if (lat !== 2) begin
            n_fail++; $display("FAIL error%0d_latency: got %0d expected 2", i, lat);
         end
         n_checks++;
         if (bb !== 0 || xd !== 0 || hb !== 0) begin
            n_fail++; $display("FAIL error%0d_busy_hold: busy errs=%0d extra done=%0d hold errs=%0d expected 0",
                               i, bb, xd, hb);
         end
      end
   endtask

   task automatic test_ignore_en();
      logic [79:0] oq, orr;
      logic        odz, oovf;
      int          lat, bb, xd, hb;
      do_op(160'd100, 80'd7, 5, 20, 6, oq, orr, odz, oovf, lat, bb, xd, hb);
      n_checks++;
      if (oq !== 80'd14 || orr !== 80'd2) begin
         n_fail++; $display("FAIL ignore_en_qr: got q=%0d r=%0d expected q=14 r=2", oq, orr);
      end
      n_checks++;
      if (lat !== 42 || xd !== 0 || bb !== 0) begin
         n_fail++; $display("FAIL ignore_en_timing: got lat=%0d extra done=%0d busy errs=%0d expected 42/0/0",
                            lat, xd, bb);
      end
   endtask

   task automatic test_back_to_back();
      logic [79:0] oq, orr, eq, er;
      logic        odz, oovf, edz, eovf;
      int          lat, elat, bb, xd, hb;
      logic [159:0] av;
      logic [79:0]  bv;
      do_op(160'd100, 80'd7, -1, -1, 0, oq, orr, odz, oovf, lat, bb, xd, hb);
      bv = rand80() | 80'd1;
      av = {rand80() % bv, rand80()};
      model(av, bv, eq, er, edz, eovf, elat);
      do_op(av, bv, -1, -1, 2, oq, orr, odz, oovf, lat, bb, xd, hb);
      n_checks++;
      if (oq !== eq || orr !== er || lat !== elat) begin
         n_fail++; $display("FAIL back_to_back: got q=%h r=%h lat=%0d expected q=%h r=%h lat=%0d",
                            oq, orr, lat, eq, er, elat);
      end
   endtask

   task automatic test_reset_mid();
      logic [79:0] oq, orr;
      logic        odz, oovf;
      int          lat, bb, xd, hb, seen_done, seen_busy;
      en = 1'b1; a = {rand80() >> 1, rand80()}; b = ~80'd0;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (21) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== 80'd0 || r !== 80'd0) begin
         n_fail++; $display("FAIL reset_mid_state: got busy=%b done=%b q=%h r=%h expected all 0",
                            busy, done, q, r);
      end
      seen_done = 0; seen_busy = 0;
      for (int i = 0; i < 50; i++) begin
         if (done) seen_done++;
         if (busy) seen_busy++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (seen_done !== 0 || seen_busy !== 0) begin
         n_fail++; $display("FAIL reset_mid_abort: got done cycles=%0d busy cycles=%0d expected 0/0",
                            seen_done, seen_busy);
      end
      do_op(160'd1000, 80'd33, -1, -1, 1, oq, orr, odz, oovf, lat, bb, xd, hb);
      n_checks++;
      if (oq !== 80'd30 || orr !== 80'd10 || lat !== 42) begin
         n_fail++; $display("FAIL reset_mid_next_op: got q=%0d r=%0d lat=%0d expected 30/10/42",
                            oq, orr, lat);
      end
   endtask

   task automatic test_random();
      logic [79:0]  oq, orr, eq, er, bv, hi, x;
      logic [159:0] av;
      logic         odz, oovf, edz, eovf;
      int           lat, elat, bb, xd, hb, mode;
      for (int i = 0; i < 30; i++) begin
         mode = int'($urandom_range(0, 5));
         bv = rand80() >> $urandom_range(0, 79);
         if (bv == 80'd0) bv = 80'd1;
         x = rand80();
         if (mode == 4) begin
            bv = 80'd0;
            hi = x;
         end else if (mode == 5) begin
            hi = (x >= bv) ? x : bv;
         end else begin
            hi = x % bv;
         end
         av = {hi, rand80()};
         model(av, bv, eq, er, edz, eovf, elat);
         do_op(av, bv, -1, -1, 1, oq, orr, odz, oovf, lat, bb, xd, hb);
         n_checks++;
         if (oq !== eq || orr !== er) begin
            n_fail++; $display("FAIL random%0d_qr: a=%h b=%h got q=%h r=%h expected q=%h r=%h",
                               i, av, bv, oq, orr, eq, er);
         end
         n_checks++;
         if ({odz, oovf} !== {edz, eovf} || lat !== elat || bb !== 0) begin
            n_fail++; $display("FAIL random%0d_ctrl: got dz/ovf=%b%b lat=%0d busy errs=%0d expected %b%b lat=%0d 0",
                               i, odz, oovf, lat, bb, edz, eovf, elat);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_directed();
      test_errors();
      test_ignore_en();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
